// File: rtl/seven_seg_reader.sv
// seven_seg_reader: watches a multiplexed active-low seven-segment bus and
// recovers the nibble shown on each digit once the pattern has been stable.
// Completed multi-digit words go downstream through a valid/ack handshake.
//
// state | meaning
// IDLE  | digit select not one-hot, stability count is 0
// TRACK | same digit/pattern seen for fewer than STABLE_CYCLES edges
// HELD  | run reached STABLE_CYCLES and was captured; wait for a change
module seven_seg_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [0:6]              hex,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    frame_ack,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   dig_valid,
  output logic [NUM_DIGITS-1:0]   dig_err,
  output logic [4*NUM_DIGITS-1:0] frame_word,
  output logic                    frame_valid,
  output logic                    overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] TOP = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [NUM_DIGITS-1:0]   prev_sel;
  logic [0:6]              prev_hex;
  logic [NUM_DIGITS-1:0]   seen, seen_nxt;
  logic [4*NUM_DIGITS-1:0] value_nxt;
  logic [NUM_DIGITS-1:0]   valid_nxt, err_nxt;
  logic                    one_hot, changed, capture, complete;
  logic [4:0]              dec;

  // Pattern a..g (hex[0]=a) to {recognized, nibble}.
  function automatic logic [4:0] decode(input logic [0:6] h);
    case (h)
      7'b0000001: decode = 5'h10;
      7'b1001111: decode = 5'h11;
      7'b0010010: decode = 5'h12;
      7'b0000110: decode = 5'h13;
      7'b1001100: decode = 5'h14;
      7'b0100100: decode = 5'h15;
      7'b0100000: decode = 5'h16;
      7'b0001111: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0000100: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b1100000: decode = 5'h1B;
      7'b0110001: decode = 5'h1C;
      7'b1000010: decode = 5'h1D;
      7'b0110000: decode = 5'h1E;
      7'b0111000: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  // Stability counting and capture decision.
  always_comb begin
    one_hot = (dig_sel != '0) && ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
    changed = (dig_sel != prev_sel) || (hex != prev_hex);
    cnt_nxt = cnt;
    if (!one_hot)         cnt_nxt = '0;
    else if (changed)     cnt_nxt = CW'(1);
    else if (cnt != TOP)  cnt_nxt = cnt + CW'(1);
    if (!one_hot)             state_nxt = IDLE;
    else if (cnt_nxt == TOP)  state_nxt = HELD;
    else                      state_nxt = TRACK;
    // a run that is already HELD and unchanged has been captured before
    capture = one_hot && (cnt_nxt == TOP) && (changed || state != HELD);
    dec     = decode(hex);
  end

  // Per-digit result and frame-completion detection for this edge.
  always_comb begin
    value_nxt = value;
    valid_nxt = dig_valid;
    err_nxt   = dig_err;
    seen_nxt  = seen;
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_sel[i]) begin
          if (dec[4]) begin
            value_nxt[4*i +: 4] = dec[3:0];
            valid_nxt[i]        = 1'b1;
            err_nxt[i]          = 1'b0;
            seen_nxt[i]         = 1'b1;
          end else begin
            valid_nxt[i] = 1'b0;
            err_nxt[i]   = 1'b1;
          end
        end
      end
    end
    complete = capture && dec[4] && (&seen_nxt);
  end

  // All registered state, including the handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      prev_sel    <= '0;
      prev_hex    <= '0;
      seen        <= '0;
      value       <= '0;
      dig_valid   <= '0;
      dig_err     <= '0;
      frame_word  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      prev_sel  <= dig_sel;
      prev_hex  <= hex;
      value     <= value_nxt;
      dig_valid <= valid_nxt;
      dig_err   <= err_nxt;
      if (complete) begin
        seen <= '0;
        if (!frame_valid || frame_ack) begin
          frame_word  <= value_nxt;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        seen <= seen_nxt;
        if (frame_ack && frame_valid) begin
          frame_valid <= 1'b0;
          overrun     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Bench for seven_seg_reader: directed scenarios plus randomized scanning,
// compared every cycle against a table-driven reference model.
module tb_seven_seg_reader;

  localparam int N = 4;
  localparam int S = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [0:6]       hex;
  logic [N-1:0]     sel;
  logic             ack;
  logic [4*N-1:0]   value, frame_word;
  logic [N-1:0]     dig_valid, dig_err;
  logic             frame_valid, overrun;

  seven_seg_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .hex(hex), .dig_sel(sel), .frame_ack(ack),
    .value(value), .dig_valid(dig_valid), .dig_err(dig_err),
    .frame_word(frame_word), .frame_valid(frame_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [0:6] pats [16];

  // reference model state
  logic [3:0]     m_val [N];
  logic [N-1:0]   m_dv, m_de, m_seen;
  logic [4*N-1:0] m_fw;
  logic           m_fv, m_ov;
  logic [N-1:0]   m_psel;
  logic [0:6]     m_phex;
  int             m_run;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [4*N-1:0] m_packed();
    logic [4*N-1:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = m_val[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_val[i] = 4'h0;
    m_dv = '0; m_de = '0; m_seen = '0; m_fw = '0; m_fv = 0; m_ov = 0;
    m_psel = '0; m_phex = '0; m_run = 0;
  endtask

  task automatic m_edge();
    bit oh, chg, done;
    int old, d, k;
    oh  = ($countones(sel) == 1);
    chg = (sel != m_psel) || (hex != m_phex);
    old = m_run;
    done = 0;
    if (!oh) m_run = 0;
    else if (chg) m_run = 1;
    else if (m_run < S) m_run++;
    m_psel = sel;
    m_phex = hex;
    if (oh && m_run == S && (chg || old < S)) begin
      d = 0;
      for (int i = 0; i < N; i++) if (sel[i]) d = i;
      k = -1;
      for (int j = 0; j < 16; j++) if (pats[j] == hex) k = j;
      if (k >= 0) begin
        m_val[d] = 4'(k); m_dv[d] = 1; m_de[d] = 0; m_seen[d] = 1;
        if (&m_seen) begin
          m_seen = '0;
          done = 1;
          if (!m_fv || ack) begin m_fw = m_packed(); m_fv = 1; end
          else m_ov = 1;
        end
      end else begin
        m_dv[d] = 0; m_de[d] = 1;
      end
    end
    if (!done && ack && m_fv) begin m_fv = 0; m_ov = 0; end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".value"}, 64'(value), 64'(m_packed()));
    chk({tag, ".dig_valid"}, 64'(dig_valid), 64'(m_dv));
    chk({tag, ".dig_err"}, 64'(dig_err), 64'(m_de));
    chk({tag, ".frame_word"}, 64'(frame_word), 64'(m_fw));
    chk({tag, ".frame_valid"}, 64'(frame_valid), 64'(m_fv));
    chk({tag, ".overrun"}, 64'(overrun), 64'(m_ov));
  endtask

  // called at a negedge; drives, clocks once, checks, returns at next negedge
  task automatic step(input logic [N-1:0] s, input logic [0:6] h, input logic a, input string tag);
    sel = s; hex = h; ack = a;
    @(posedge clk);
    m_edge();
    #1 check_all(tag);
    @(negedge clk);
  endtask

  task automatic show(input int dig, input int nib, input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) step(N'(1) << dig, pats[nib], 1'b0, tag);
  endtask

  initial begin
    logic [0:6] h;
    logic [N-1:0] s;
    int dw;
    pats[0]  = 7'b0000001; pats[1]  = 7'b1001111; pats[2]  = 7'b0010010; pats[3]  = 7'b0000110;
    pats[4]  = 7'b1001100; pats[5]  = 7'b0100100; pats[6]  = 7'b0100000; pats[7]  = 7'b0001111;
    pats[8]  = 7'b0000000; pats[9]  = 7'b0000100; pats[10] = 7'b0001000; pats[11] = 7'b1100000;
    pats[12] = 7'b0110001; pats[13] = 7'b1000010; pats[14] = 7'b0110000; pats[15] = 7'b0111000;
    m_reset();

    // reset held with a valid-looking digit: nothing may change
    rst = 1; sel = 4'b0001; hex = 7'b0000000; ack = 0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1 check_all("reset");
      @(negedge clk);
    end
    rst = 0;

    // basic capture: 5 on digit 0, visible after edge 3 only
    step(4'b0001, pats[5], 0, "cap5_e1");
    step(4'b0001, pats[5], 0, "cap5_e2");
    chk("cap5_not_yet", 64'(dig_valid), 64'h0);
    step(4'b0001, pats[5], 0, "cap5_e3");
    chk("cap5_value", 64'(value[3:0]), 64'h5);
    chk("cap5_valid", 64'(dig_valid), 64'h1);

    // glitch on the second edge delays capture on digit 1
    step(4'b0010, pats[5], 0, "glitch_e1");
    step(4'b0010, pats[5] ^ 7'b0000010, 0, "glitch_e2");
    step(4'b0010, pats[5], 0, "glitch_e3");
    step(4'b0010, pats[5], 0, "glitch_e4");
    chk("glitch_delayed", 64'(dig_valid[1]), 64'h0);
    step(4'b0010, pats[5], 0, "glitch_e5");
    chk("glitch_captured", 64'(dig_valid[1]), 64'h1);

    // unrecognized pattern on digit 2
    for (int c = 0; c < 3; c++) step(4'b0100, 7'b1111111, 0, "bad");
    chk("bad_err", 64'(dig_err[2]), 64'h1);
    chk("bad_valid", 64'(dig_valid[2]), 64'h0);
    chk("bad_value", 64'(value[11:8]), 64'h0);
    chk("bad_noframe", 64'(frame_valid), 64'h0);

    // full frame 1,2,3,4
    for (int d = 0; d < 4; d++) show(d, d + 1, 3, "frame1");
    chk("frame1_valid", 64'(frame_valid), 64'h1);
    chk("frame1_word", 64'(frame_word), 64'h4321);

    // second frame without ack -> overrun, word kept
    show(0, 8, 3, "frame2"); show(1, 7, 3, "frame2"); show(2, 6, 3, "frame2"); show(3, 5, 3, "frame2");
    chk("frame2_word_kept", 64'(frame_word), 64'h4321);
    chk("frame2_overrun", 64'(overrun), 64'h1);
    chk("frame2_value", 64'(value), 64'h5678);
    step(4'b0000, 7'b1111111, 1, "ack");
    chk("ack_fv", 64'(frame_valid), 64'h0);
    chk("ack_ov", 64'(overrun), 64'h0);
    step(4'b0000, 7'b1111111, 1, "ack_idle");

    // short dwells never capture
    step(4'b0001, pats[9], 0, "short"); step(4'b0001, pats[9], 0, "short");
    step(4'b1000, pats[9], 0, "short"); step(4'b1000, pats[9], 0, "short");
    chk("short_nocap", 64'(value), 64'h5678);

    // randomized scanning
    for (int seg = 0; seg < 400; seg++) begin
      case ($urandom_range(0, 9))
        0: s = '0;
        1: s = 4'b0011 << $urandom_range(0, 2);
        default: s = N'(1) << $urandom_range(0, N - 1);
      endcase
      h = ($urandom_range(0, 5) == 0) ? 7'($urandom) : pats[$urandom_range(0, 15)];
      dw = $urandom_range(1, 5);
      for (int c = 0; c < dw; c++) begin
        if ($urandom_range(0, 9) == 0)
          step(s, h ^ (7'b1 << $urandom_range(0, 6)), $urandom_range(0, 4) == 0, "rand");
        else
          step(s, h, $urandom_range(0, 4) == 0, "rand");
      end
    end

    // asynchronous reset mid-scan
    show(0, 3, 3, "pre_rst"); show(1, 4, 2, "pre_rst");
    #2 rst = 1;
    #1;
    m_reset();
    check_all("async_rst");
    chk("async_rst_value", 64'(value), 64'h0);
    @(negedge clk);
    rst = 0;
    show(2, 7, 3, "post_rst");
    chk("post_rst_value", 64'(value), 64'h0700);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
